pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer for the core fetch stage.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with branch, jump and call/return stack
//
// Optional feature macro: PC_SEQ_HALT_EN
//   When defined, adds halt_req/halted and a sticky halt that freezes pc and the
//   return-address stack until reset. When undefined, the sequencer never freezes
//   itself.
//
// Return-address stack: r_ptr names the next slot to write and the top of stack
// is r_ptr-1. Both wrap mod RAS_DEPTH, so a push on a full stack overwrites the
// oldest entry. r_count saturates at RAS_DEPTH.

module pc_sequencer #(
    parameter int PC_W      = 32,
    parameter int IMM_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             branch_ne,
    input  logic             zero,
    input  logic [IMM_W-1:0] imm,
    input  logic             jump_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [PC_W-1:0]  target,
`ifdef PC_SEQ_HALT_EN
    input  logic             halt_req,
    output logic             halted,
`endif
    output logic [PC_W-1:0]  pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  r_pc;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];

    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_imm_ext;
    logic [PC_W-1:0]  w_branch_pc;
    logic [PTR_W-1:0] w_top_ptr;
    logic             w_taken;
    logic             w_hold;
    logic             w_empty;
    logic             w_full;
    logic             w_do_ret;
    logic             w_do_push;

    // Arithmetic is plain modulo-2**PC_W wrap; branch offset is relative to pc+1.
    assign w_pc_inc    = r_pc + PC_W'(1);
    assign w_imm_ext   = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_branch_pc = w_pc_inc + w_imm_ext;
    assign w_top_ptr   = r_ptr - PTR_W'(1);
    assign w_taken     = branch_en & (zero ^ branch_ne);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(RAS_DEPTH));

`ifdef PC_SEQ_HALT_EN
    logic r_halted;

    // Sticky halt: set by an unstalled halt_req, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (!stall && halt_req) begin
            r_halted <= 1'b1;
        end
    end

    assign halted = r_halted;
    // A halt request takes the edge itself, so pc does not advance on it.
    assign w_hold = stall | r_halted | halt_req;
`else
    assign w_hold = stall;
`endif

    // A return always beats a call in the same cycle; the call is simply dropped.
    assign w_do_ret  = !w_hold && ret_en;
    assign w_do_push = !w_hold && !ret_en && call_en;

    // PC, stack pointer, count and sticky error, in priority order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (!w_hold) begin
            if (ret_en) begin
                if (!w_empty) begin
                    r_pc    <= r_ras[w_top_ptr];
                    r_ptr   <= w_top_ptr;
                    r_count <= r_count - CNT_W'(1);
                end else begin
                    r_pc  <= w_pc_inc;
                    r_err <= 1'b1;
                end
            end else if (call_en) begin
                r_pc  <= target;
                r_ptr <= r_ptr + PTR_W'(1);
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (jump_en) begin
                r_pc <= target;
            end else if (w_taken) begin
                r_pc <= w_branch_pc;
            end else begin
                r_pc <= w_pc_inc;
            end
        end
    end

    // Stack storage needs no reset; only slots below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_ras[r_ptr] <= w_pc_inc;
        end
    end

    assign pc        = r_pc;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_err   = r_err;

    // w_do_ret is kept for readability of the push qualifier; tie it off here.
    logic w_unused;
    assign w_unused = w_do_ret;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer with queue-based reference model

module tb_pc_sequencer;

    localparam int PC_W  = 32;
    localparam int IMM_W = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             branch_en;
    logic             branch_ne;
    logic             zero;
    logic [IMM_W-1:0] imm;
    logic             jump_en;
    logic             call_en;
    logic             ret_en;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;
`ifdef PC_SEQ_HALT_EN
    logic             halt_req;
    logic             halted;
`endif

    pc_sequencer #(.PC_W(PC_W), .IMM_W(IMM_W), .RAS_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .branch_en (branch_en),
        .branch_ne (branch_ne),
        .zero      (zero),
        .imm       (imm),
        .jump_en   (jump_en),
        .call_en   (call_en),
        .ret_en    (ret_en),
        .target    (target),
`ifdef PC_SEQ_HALT_EN
        .halt_req  (halt_req),
        .halted    (halted),
`endif
        .pc        (pc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the stack is a queue whose back is the top.
    logic [PC_W-1:0] m_pc;
    logic            m_err;
    logic            m_halted;
    logic [PC_W-1:0] m_ras[$];

    task automatic check(input string tag, input logic [PC_W-1:0] got, input logic [PC_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = '0;
        m_err    = 1'b0;
        m_halted = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step(input logic st, input logic hr);
        logic [PC_W-1:0] seq;
        seq = m_pc + 32'd1;
        if (st || m_halted) return;
        if (hr) begin
            m_halted = 1'b1;
            return;
        end
        if (ret_en) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
                m_pc  = seq;
                m_err = 1'b1;
            end
        end else if (call_en) begin
            m_ras.push_back(seq);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            m_pc = target;
        end else if (jump_en) begin
            m_pc = target;
        end else if (branch_en && (zero != branch_ne)) begin
            m_pc = seq + 32'($signed(imm));
        end else begin
            m_pc = seq;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
        check({tag, ".full"}, 32'(ras_full), 32'(m_ras.size() == DEPTH));
        check({tag, ".err"}, 32'(ras_err), 32'(m_err));
`ifdef PC_SEQ_HALT_EN
        check({tag, ".halted"}, 32'(halted), 32'(m_halted));
`endif
    endtask

    task automatic idle_inputs();
        stall = 0; branch_en = 0; branch_ne = 0; zero = 0; imm = '0;
        jump_en = 0; call_en = 0; ret_en = 0; target = '0;
`ifdef PC_SEQ_HALT_EN
        halt_req = 0;
`endif
    endtask

    // Apply the currently driven inputs for one edge and compare against the model.
    task automatic cycle(input string tag, input logic hr);
`ifdef PC_SEQ_HALT_EN
        halt_req = hr;
`endif
        model_step(stall, hr);
        @(posedge clk);
        #1;
        compare_all(tag);
        idle_inputs();
    endtask

    task automatic do_idle(input string tag);
        idle_inputs();
        cycle(tag, 1'b0);
    endtask

    task automatic do_jump(input logic [PC_W-1:0] t);
        idle_inputs(); jump_en = 1; target = t;
        cycle("jump", 1'b0);
    endtask

    task automatic do_call(input logic [PC_W-1:0] t);
        idle_inputs(); call_en = 1; target = t;
        cycle("call", 1'b0);
    endtask

    task automatic do_ret();
        idle_inputs(); ret_en = 1;
        cycle("ret", 1'b0);
    endtask

    task automatic do_branch(input logic z, input logic ne, input logic [7:0] im);
        idle_inputs(); branch_en = 1; zero = z; branch_ne = ne; imm = im;
        cycle("branch", 1'b0);
    endtask

    // Reset asserted between edges must take effect immediately.
    task automatic mid_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        compare_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Increment from reset.
        check("inc0", pc, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            do_idle("inc");
            check("inc_val", pc, 32'(i));
        end

        // Conditional branches, offset -4 relative to pc+1.
        do_jump(32'd10);
        do_branch(1'b1, 1'b0, 8'hFC);
        check("beqz_taken", pc, 32'd7);
        do_jump(32'd10);
        do_branch(1'b0, 1'b0, 8'hFC);
        check("beqz_not_taken", pc, 32'd11);
        do_jump(32'd10);
        do_branch(1'b0, 1'b1, 8'hFC);
        check("bnez_taken", pc, 32'd7);

        // Call / return, single and nested.
        do_jump(32'd20);
        do_call(32'd100);
        check("call_pc", pc, 32'd100);
        do_ret();
        check("ret_pc", pc, 32'd21);
        do_jump(32'd30);
        do_call(32'd200);
        do_call(32'd300);
        do_ret();
        check("nest_ret1", pc, 32'd201);
        do_ret();
        check("nest_ret2", pc, 32'd31);
        check("nest_empty", 32'(ras_empty), 32'd1);

        // Overflow: five calls on a four-deep stack drop the oldest return address.
        do_jump(32'd40);
        do_call(32'd50);
        do_call(32'd60);
        do_call(32'd70);
        do_call(32'd80);
        do_call(32'd90);
        check("ovf_full", 32'(ras_full), 32'd1);
        check("ovf_err_clear", 32'(ras_err), 32'd0);
        do_ret(); check("ovf_ret1", pc, 32'd81);
        do_ret(); check("ovf_ret2", pc, 32'd71);
        do_ret(); check("ovf_ret3", pc, 32'd61);
        do_ret(); check("ovf_ret4", pc, 32'd51);
        do_ret();
        check("underflow_pc", pc, 32'd52);
        check("underflow_err", 32'(ras_err), 32'd1);

        // Stall beats everything.
        do_call(32'd500);
        idle_inputs(); stall = 1; ret_en = 1; jump_en = 1; target = 32'd777;
        cycle("stall", 1'b0);
        check("stall_hold", pc, 32'd500);
        check("stall_ras", 32'(ras_empty), 32'd0);

        // Call and return together: pop only.
        idle_inputs(); call_en = 1; ret_en = 1; target = 32'd900;
        cycle("call_ret", 1'b0);
        check("call_ret_pc", pc, 32'd53);
        check("call_ret_empty", 32'(ras_empty), 32'd1);

        // PC wrap.
        do_jump(32'hFFFF_FFFF);
        do_idle("wrap");
        check("wrap_pc", pc, 32'd0);

        // Reset between edges after two calls.
        do_call(32'd60);
        do_call(32'd70);
        mid_reset("midreset");
        check("midreset_pc", pc, 32'd0);

`ifdef PC_SEQ_HALT_EN
        do_jump(32'd9);
        idle_inputs();
        cycle("halt", 1'b1);
        check("halt_pc", pc, 32'd9);
        check("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); jump_en = 1; target = 32'($urandom); call_en = 1'($urandom);
            cycle("halted_frozen", 1'b0);
        end
        check("halt_still_pc", pc, 32'd9);
        mid_reset("halt_reset");
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            stall     = ($urandom_range(7) == 0);
            ret_en    = ($urandom_range(5) == 0);
            call_en   = ($urandom_range(4) == 0);
            jump_en   = ($urandom_range(9) == 0);
            branch_en = ($urandom_range(2) == 0);
            branch_ne = 1'($urandom);
            zero      = 1'($urandom);
            imm       = 8'($urandom);
            target    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                                 : 32'($urandom);
            cycle("rand", 1'b0);
            if (n == 200) mid_reset("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
